// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the LEGv8 stall/flush controller.
// Holds the FSM state encoding, the zero-register index and defaults.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    localparam logic [4:0] XZR = 5'd31;

    localparam int TIMEOUT_DEF = 256;
    localparam int CNT_W_DEF   = 32;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Bundle between the stall controller and the pipeline datapath.
// master: controller (hazard/memory inputs, enable/flush/counter outputs).
// slave : pipeline side (drives hazard/memory, receives controls).
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRd;
    logic [4:0]       IF_ID_RegisterRn1;
    logic [4:0]       IF_ID_RegisterRm2;
    logic             EX_MEM_BranchTaken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             PCWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             EX_MEM_Write;
    logic             ControlMux;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             MEM_WB_Bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  ID_EX_MemRead, ID_EX_RegisterRd,
        input  IF_ID_RegisterRn1, IF_ID_RegisterRm2,
        input  EX_MEM_BranchTaken, dmem_req, dmem_ready,
        output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
        output ControlMux, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        output MEM_WB_Bubble, halted, stall_cycles, flush_count
    );

    modport slave (
        output ID_EX_MemRead, ID_EX_RegisterRd,
        output IF_ID_RegisterRn1, IF_ID_RegisterRm2,
        output EX_MEM_BranchTaken, dmem_req, dmem_ready,
        input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
        input  ControlMux, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        input  MEM_WB_Bubble, halted, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the performance counters.
// Ports: clk, rst_n (async low), inc, clear (sync), count (W bits).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with memory watchdog.
// Ports: clk, rst_n (async low), bus (master: hazards in, controls out).
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic clk,
    input logic rst_n,
    pipeline_stall_controller_if.master bus
);

    localparam int              WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic load_use;
    logic mem_stall;
    logic freeze;
    logic halt_o;
    logic br_flush;
    logic lu_stall;

    always_comb begin
        load_use = bus.ID_EX_MemRead
                && (bus.ID_EX_RegisterRd != XZR)
                && ((bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRn1)
                 || (bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRm2));
        mem_stall = bus.dmem_req && !bus.dmem_ready;

        state_d  = state_q;
        wait_d   = wait_q;
        freeze   = 1'b0;
        halt_o   = 1'b0;
        br_flush = 1'b0;
        lu_stall = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (mem_stall) begin
                    freeze  = 1'b1;
                    state_d = S_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else if (bus.EX_MEM_BranchTaken) begin
                    br_flush = 1'b1;
                end else if (load_use) begin
                    lu_stall = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    // Release cycle behaves like S_RUN without the memory stall.
                    state_d = S_RUN;
                    wait_d  = '0;
                    if (bus.EX_MEM_BranchTaken) begin
                        br_flush = 1'b1;
                    end else if (load_use) begin
                        lu_stall = 1'b1;
                    end
                end else begin
                    freeze = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            S_HALT: begin
                halt_o = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase

        // Held in reset: outputs take their run-idle values whatever the inputs.
        if (!rst_n) begin
            freeze   = 1'b0;
            halt_o   = 1'b0;
            br_flush = 1'b0;
            lu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.PCWrite       = !(freeze || halt_o || lu_stall);
    assign bus.IF_ID_Write   = !(freeze || halt_o || lu_stall);
    assign bus.ID_EX_Write   = !(freeze || halt_o);
    assign bus.EX_MEM_Write  = !(freeze || halt_o);
    assign bus.ControlMux    = lu_stall;
    assign bus.IF_ID_Flush   = br_flush;
    assign bus.ID_EX_Flush   = br_flush;
    assign bus.EX_MEM_Flush  = br_flush;
    assign bus.MEM_WB_Bubble = freeze || halt_o;
    assign bus.halted        = halt_o;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!bus.PCWrite),
        .clear (1'b0),
        .count (bus.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_flush),
        .clear (1'b0),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller.
// dut_a: TIMEOUT=8, 32-bit counters; dut_b: TIMEOUT=4, 3-bit counters.
module tb_pipeline_stall_controller;

    // {PCWrite,IF_ID_W,ID_EX_W,EX_MEM_W,CtrlMux,IF_F,ID_F,EX_F,Bubble,halted}
    localparam logic [9:0] C_NONE = 10'b1111_000_0_0_0;
    localparam logic [9:0] C_LU   = 10'b0011_100_0_0_0;
    localparam logic [9:0] C_BR   = 10'b1111_011_1_0_0;
    localparam logic [9:0] C_MS   = 10'b0000_000_0_1_0;
    localparam logic [9:0] C_HALT = 10'b0000_000_0_1_1;

    typedef struct {
        int          dut;
        logic [9:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic       mr, br, rq, rdy;
    logic [4:0] rd, rn, rm;

    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_W(32)) ifa ();
    pipeline_stall_controller_if #(.CNT_W(3))  ifb ();

    assign ifa.ID_EX_MemRead      = mr;
    assign ifa.ID_EX_RegisterRd   = rd;
    assign ifa.IF_ID_RegisterRn1  = rn;
    assign ifa.IF_ID_RegisterRm2  = rm;
    assign ifa.EX_MEM_BranchTaken = br;
    assign ifa.dmem_req           = rq;
    assign ifa.dmem_ready         = rdy;
    assign ifb.ID_EX_MemRead      = mr;
    assign ifb.ID_EX_RegisterRd   = rd;
    assign ifb.IF_ID_RegisterRn1  = rn;
    assign ifb.IF_ID_RegisterRm2  = rm;
    assign ifb.EX_MEM_BranchTaken = br;
    assign ifb.dmem_req           = rq;
    assign ifb.dmem_ready         = rdy;

    pipeline_stall_controller #(.TIMEOUT(8), .CNT_W(32)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (ifa)
    );

    pipeline_stall_controller #(.TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (ifb)
    );

    function automatic logic [9:0] ctrl_a();
        return {ifa.PCWrite, ifa.IF_ID_Write, ifa.ID_EX_Write,
                ifa.EX_MEM_Write, ifa.ControlMux, ifa.IF_ID_Flush,
                ifa.ID_EX_Flush, ifa.EX_MEM_Flush, ifa.MEM_WB_Bubble,
                ifa.halted};
    endfunction

    function automatic logic [9:0] ctrl_b();
        return {ifb.PCWrite, ifb.IF_ID_Write, ifb.ID_EX_Write,
                ifb.EX_MEM_Write, ifb.ControlMux, ifb.IF_ID_Flush,
                ifb.ID_EX_Flush, ifb.EX_MEM_Flush, ifb.MEM_WB_Bubble,
                ifb.halted};
    endfunction

    task automatic push(input int dut, input logic [9:0] ec,
                        input int es, input int ef);
        exp_t e;
        e.dut   = dut;
        e.ctrl  = ec;
        e.stall = 32'(es);
        e.flush = 32'(ef);
        sbq.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t        e;
        logic [9:0]  oc;
        logic [31:0] os, of;
        e = sbq.pop_front();
        if (e.dut == 0) begin
            oc = ctrl_a();
            os = ifa.stall_cycles;
            of = ifa.flush_count;
        end else begin
            oc = ctrl_b();
            os = 32'(ifb.stall_cycles);
            of = 32'(ifb.flush_count);
        end
        total++;
        assert (oc === e.ctrl) else begin
            bad++;
            $error("FAIL %s ctrl got=%b want=%b", tag, oc, e.ctrl);
        end
        total++;
        assert (os === e.stall) else begin
            bad++;
            $error("FAIL %s stall_cycles got=%0d want=%0d", tag, os, e.stall);
        end
        total++;
        assert (of === e.flush) else begin
            bad++;
            $error("FAIL %s flush_count got=%0d want=%0d", tag, of, e.flush);
        end
    endtask

    task automatic drive(input logic m, input logic [4:0] d,
                         input logic [4:0] n, input logic [4:0] r,
                         input logic b, input logic q, input logic y);
        mr  = m;
        rd  = d;
        rn  = n;
        rm  = r;
        br  = b;
        rq  = q;
        rdy = y;
    endtask

    // One cycle: drive at negedge, check combinational outputs mid-cycle.
    task automatic step(input int dut, input logic m, input logic [4:0] d,
                        input logic [4:0] n, input logic [4:0] r,
                        input logic b, input logic q, input logic y,
                        input logic [9:0] ec, input int es, input int ef,
                        input string tag);
        @(negedge clk);
        drive(m, d, n, r, b, q, y);
        push(dut, ec, es, ef);
        #2;
        sample(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        // Load-use pattern present while in reset: outputs must stay idle.
        drive(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
        #3;
        push(0, C_NONE, 0, 0);
        sample("a_reset");
        push(1, C_NONE, 0, 0);
        sample("b_reset");

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_a = 1'b1;

        step(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, "a_idle");
        step(0, 1, 1, 1, 0, 0, 0, 0, C_LU, 0, 0, "a_lu_rn1");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, "a_after_lu");
        step(0, 1, 5, 2, 5, 0, 0, 0, C_LU, 1, 0, "a_lu_rm2");
        step(0, 1, 31, 31, 31, 0, 0, 0, C_NONE, 2, 0, "a_xzr");
        step(0, 0, 1, 1, 1, 0, 0, 0, C_NONE, 2, 0, "a_no_load");
        step(0, 1, 1, 1, 0, 1, 0, 0, C_BR, 2, 0, "a_br_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2, 1, "a_after_br");
        step(0, 0, 0, 0, 0, 0, 1, 0, C_MS, 2, 1, "a_mw1");
        step(0, 1, 1, 1, 0, 1, 1, 0, C_MS, 3, 1, "a_mw2_ign");
        step(0, 0, 0, 0, 0, 0, 1, 0, C_MS, 4, 1, "a_mw3");
        step(0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 5, 1, "a_release");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 5, 1, "a_post_rel");
        step(0, 0, 0, 0, 0, 0, 1, 0, C_MS, 5, 1, "a_mw4");
        step(0, 0, 0, 0, 0, 1, 1, 1, C_BR, 6, 1, "a_rel_br");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 6, 2, "a_post_br");

        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b1;

        step(1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, "b_idle");
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 1, 0, C_MS, i, 0, "b_wait");
        end
        step(1, 0, 0, 0, 0, 0, 1, 0, C_HALT, 4, 0, "b_halt");
        step(1, 1, 1, 1, 0, 1, 1, 1, C_HALT, 5, 0, "b_halt_hold");

        // Asynchronous reset before the next rising edge.
        #1;
        rst_b = 1'b0;
        #1;
        push(1, C_NONE, 0, 0);
        sample("b_async_rst");

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step(1, 1, 3, 0, 3, 0, 0, 0, C_LU, (i < 7) ? i : 7, 0, "b_sat");
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 7, 0, "b_sat_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
